// File: rtl/ccff_bitstream_loader_if.sv
// Word handshake between the programming-side source (host FIFO / SPI) and the chain loader.
// The source drives data and valid; the loader answers with ready.
interface ccff_bitstream_loader_if #(
   parameter int WORD_W = 8
) ();
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;

   modport master (output word_data, output word_valid, input word_ready);
   modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first onto the configuration chain head, one bit per shift_en,
// and in verify mode compares the chain tail against the re-shifted bitstream.
module ccff_bitstream_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 512
) (
   input  logic                    prog_clk,
   input  logic                    prog_rst_n,
   input  logic                    start,
   input  logic                    verify,
   ccff_bitstream_loader_if.slave  word_if,
   output logic                    ccff_head,
   output logic                    shift_en,
   input  logic                    ccff_tail,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);
   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int SC_W      = $clog2(WORD_W + 1);
   localparam int WT_W      = $clog2(NWORDS + 1);

   localparam logic [SC_W-1:0]  FULL_CNT   = SC_W'(WORD_W);
   localparam logic [SC_W-1:0]  LAST_CNT   = SC_W'(LAST_BITS);
   localparam logic [WT_W-1:0]  NWORDS_C   = WT_W'(NWORDS);
   localparam logic [WT_W-1:0]  LAST_WORD  = WT_W'(NWORDS - 1);
   localparam logic [CNT_W-1:0] LAST_CHAIN = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [SC_W-1:0]   sreg_cnt_q, sreg_cnt_d;
   logic [CNT_W-1:0]  chain_cnt_q, chain_cnt_d;
   logic [WT_W-1:0]   words_taken_q, words_taken_d;

   logic shift_en_s;
   logic head_s;
   logic word_ready_s;
   logic accept_s;

   // Shift enable, head bit and ready are decoded straight from the shift register state.
   always_comb begin
      shift_en_s   = (sreg_cnt_q != {SC_W{1'b0}});
      head_s       = shift_en_s & sreg_q[WORD_W-1];
      word_ready_s = (state_q == S_SHIFT)
                     && ((sreg_cnt_q == {SC_W{1'b0}}) || ((sreg_cnt_q == SC_W'(1)) && shift_en_s))
                     && (words_taken_q < NWORDS_C);
      accept_s     = word_ready_s & word_if.word_valid;
   end

   assign shift_en         = shift_en_s;
   assign ccff_head        = head_s;
   assign word_if.word_ready = word_ready_s;
   assign busy             = busy_q;
   assign done             = done_q;
   assign err              = err_q;

   // Next-state logic; a load in the cycle of the last shift overrides the shift so bits stay gap-free.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      err_d         = err_q;
      sreg_d        = sreg_q;
      sreg_cnt_d    = sreg_cnt_q;
      chain_cnt_d   = chain_cnt_q;
      words_taken_d = words_taken_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_SHIFT;
               mode_d        = verify;
               err_d         = 1'b0;
               sreg_d        = {WORD_W{1'b0}};
               sreg_cnt_d    = {SC_W{1'b0}};
               chain_cnt_d   = {CNT_W{1'b0}};
               words_taken_d = {WT_W{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (shift_en_s) begin
               sreg_d      = sreg_q << 1;
               sreg_cnt_d  = sreg_cnt_q - SC_W'(1);
               chain_cnt_d = chain_cnt_q + CNT_W'(1);
               if (mode_q && (ccff_tail != head_s)) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
               if (chain_cnt_q == LAST_CHAIN) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SHIFT;
               end
            end else begin
               state_d = S_SHIFT;
            end
            if (accept_s) begin
               sreg_d        = word_if.word_data;
               sreg_cnt_d    = (words_taken_q == LAST_WORD) ? LAST_CNT : FULL_CNT;
               words_taken_d = words_taken_q + WT_W'(1);
            end else begin
               words_taken_d = words_taken_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_SHIFT);
      done_d = (state_d == S_DONE);
   end

   // State and output registers.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_q       <= S_IDLE;
         mode_q        <= 1'b0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         sreg_q        <= {WORD_W{1'b0}};
         sreg_cnt_q    <= {SC_W{1'b0}};
         chain_cnt_q   <= {CNT_W{1'b0}};
         words_taken_q <= {WT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         err_q         <= err_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         sreg_q        <= sreg_d;
         sreg_cnt_q    <= sreg_cnt_d;
         chain_cnt_q   <= chain_cnt_d;
         words_taken_q <= words_taken_d;
      end
   end
endmodule
